// File: rtl/uart_inst_loader_pkg.sv
// rtl/uart_inst_loader_pkg.sv - shared constants and receiver state encoding for the UART instruction loader
package uart_inst_loader_pkg;

  // addi x0,x0,0: presented to fetch whenever no host word is buffered
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with input synchronizer, byte strobe and frame error pulse
module uart_rx
  import uart_inst_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       frame_err,
  output logic       idle
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  logic      rx_meta_q;
  logic      rx_sync_q;
  rx_state_e state_q;
  logic [CW-1:0] baud_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       byte_strobe_q;
  logic       frame_err_q;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver FSM: centre-samples start, 8 data bits LSB-first, then stop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RX_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      byte_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      byte_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            state_q <= RX_START;
            baud_q  <= '0;
            bit_q   <= '0;
          end
        end
        RX_START: begin
          if (baud_q == HALF_BIT) begin
            baud_q  <= '0;
            // a line already back high at mid start bit was only a glitch
            state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_q == FULL_BIT) begin
            baud_q  <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_q == FULL_BIT) begin
            baud_q        <= '0;
            state_q       <= RX_IDLE;
            byte_strobe_q <= rx_sync_q;
            frame_err_q   <= !rx_sync_q;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_data   = shift_q;
  assign byte_strobe = byte_strobe_q;
  assign frame_err   = frame_err_q;
  assign idle        = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_inst_loader.sv
// rtl/uart_inst_loader.sv - UART byte stream to 32-bit instruction FIFO feeding the fetch stage
// Optional partial-word timeout is built only when UART_LOADER_TIMEOUT_EN is defined.
module uart_inst_loader
  import uart_inst_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 4,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  input  logic                   inst_take,
  output logic [31:0]            inst_out,
  output logic                   inst_valid,
  output logic                   frame_err,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic        rx_frame_err;
  logic        rx_idle;
  logic        timeout;

  logic [1:0]  idx_q;
  logic [23:0] word_q;
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic        overflow_q;

  logic        push;
  logic        pop;
  logic        full;
  logic        wr_en;
  logic [31:0] push_word;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_data  (rx_byte),
    .byte_strobe(rx_strobe),
    .frame_err  (rx_frame_err),
    .idle       (rx_idle)
  );

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmo_cnt_q;

  assign timeout = rx_idle && (idx_q != 2'd0) && (tmo_cnt_q == TW'(TIMEOUT_CLKS));

  // Idle-gap counter for a partially assembled word; restarts on every byte
  always_ff @(posedge clk) begin
    if (reset || rx_strobe || rx_frame_err || idx_q == 2'd0 || timeout) begin
      tmo_cnt_q <= '0;
    end else if (rx_idle) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  // Partial words wait forever; the idle flag and timeout value have no consumer here
  localparam int unused_timeout_clks = TIMEOUT_CLKS;
  logic unused_rx_idle;
  assign unused_rx_idle = rx_idle;
  assign timeout        = 1'b0;
`endif

  assign push      = rx_strobe && (idx_q == 2'd3);
  assign pop       = inst_take && (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign wr_en     = push && (!full || pop);
  assign push_word = {rx_byte, word_q};

  // Byte assembler: first byte lands in the LSB; frame errors and timeouts drop the partial word
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (rx_frame_err) begin
      idx_q <= '0;
    end else if (rx_strobe) begin
      case (idx_q)
        2'd0:    word_q[7:0]   <= rx_byte;
        2'd1:    word_q[15:8]  <= rx_byte;
        2'd2:    word_q[23:16] <= rx_byte;
        default: ;
      endcase
      idx_q <= idx_q + 1'b1;
    end else if (timeout) begin
      idx_q <= '0;
    end
  end

  // Next occupancy from the accepted write and pop of this edge
  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents are only visible while level is non-zero
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_word;
  end

  // FIFO pointers, occupancy and the sticky dropped-word flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign inst_valid = (level_q != '0);
  assign inst_out   = inst_valid ? mem_q[rd_ptr_q] : NOP_INST;
  assign frame_err  = rx_frame_err;
  assign overflow   = overflow_q;
  assign level      = level_q;

endmodule
